mem_load_ctrl: RTL and testbench

- Boot and load sequencer between the external loader stream (bench or host) and the processor's instruction RAM and data RAM.
- Accepts load commands and a word stream, and writes each word with fixed address/data setup and hold margins, so memory writes do not overlap or overwrite each other.
- After loading, releases the processor with a start pulse and hands both memory ports to the CPU until it halts.

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/mem_load_ctrl_if.sv | 28 ++
 rtl/mem_port_mux.sv | 34 +++
 rtl/mem_load_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mem_load_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared states, targets and defaults for the memory load sequencer
package mem_ctrl_pkg;

   localparam int DEF_ADDR_W = 9;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_DEPTH  = 512;

   localparam logic TGT_IRAM = 1'b0;
   localparam logic TGT_DRAM = 1'b1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_DATA = 3'd1,
      SETUP     = 3'd2,
      WRITE     = 3'd3,
      HOLD      = 3'd4,
      START     = 3'd5,
      RUN       = 3'd6
   } state_e;

endpackage

// File: rtl/mem_load_ctrl_if.sv
// rtl/mem_load_ctrl_if.sv - loader command and word stream handshake bundle
interface mem_load_ctrl_if
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_target;
   logic [ADDR_W-1:0] cmd_base;
   logic [ADDR_W:0]   cmd_len;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;

   modport master (
      output cmd_valid, cmd_target, cmd_base, cmd_len, in_valid, in_data,
      input  cmd_ready, in_ready
   );

   modport slave (
      input  cmd_valid, cmd_target, cmd_base, cmd_len, in_valid, in_data,
      output cmd_ready, in_ready
   );

endinterface

// File: rtl/mem_port_mux.sv
// rtl/mem_port_mux.sv - combinational loader/CPU selector for the data RAM port
module mem_port_mux #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic              cpu_own,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re
);

   // The loader never reads, so mem_re is purely the CPU's and masked otherwise.
   always_comb begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      mem_we    = ld_we;
      mem_re    = 1'b0;
      if (cpu_own) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_we;
         mem_re    = cpu_re;
      end
   end

endmodule

// File: rtl/mem_load_ctrl.sv
// rtl/mem_load_ctrl.sv - boot loader sequencer writing iram/dram with setup/hold margins, then running the CPU
module mem_load_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int WR_SETUP = 1,
   parameter int WR_HOLD  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_load_ctrl_if.slave      lif,
   input  logic                run_req,
   output logic                cpu_start,
   input  logic                cpu_halt,
   input  logic [ADDR_W-1:0]   cpu_iram_addr,
   input  logic [ADDR_W-1:0]   cpu_dram_addr,
   input  logic [DATA_W-1:0]   cpu_dram_wdata,
   input  logic                cpu_dram_we,
   input  logic                cpu_dram_re,
   output logic [ADDR_W-1:0]   iram_addr,
   output logic [DATA_W-1:0]   iram_wdata,
   output logic                iram_we,
   output logic [ADDR_W-1:0]   dram_addr,
   output logic [DATA_W-1:0]   dram_wdata,
   output logic                dram_we,
   output logic                dram_re,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam logic [2:0] ST_IDLE      = IDLE;
   localparam logic [2:0] ST_WAIT_DATA = WAIT_DATA;
   localparam logic [2:0] ST_SETUP     = SETUP;
   localparam logic [2:0] ST_WRITE     = WRITE;
   localparam logic [2:0] ST_HOLD      = HOLD;
   localparam logic [2:0] ST_START     = START;
   localparam logic [2:0] ST_RUN       = RUN;

   localparam logic [3:0]        SETUP_LAST = 4'(WR_SETUP - 1);
   localparam logic [3:0]        HOLD_LAST  = 4'(WR_HOLD - 1);
   localparam logic [ADDR_W+1:0] DEPTH_W    = (ADDR_W+2)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE    = (ADDR_W+1)'(1);

   logic [2:0]        state_q, state_d;
   logic              tgt_q, tgt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   // Bounds check is done one bit wider than base+len can reach so it never wraps.
   logic [ADDR_W+1:0] end_addr;
   assign end_addr = {2'b00, lif.cmd_base} + {1'b0, lif.cmd_len};

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (lif.cmd_valid) begin
               tgt_d  = lif.cmd_target;
               addr_d = lif.cmd_base;
               rem_d  = lif.cmd_len;
               if (lif.cmd_len == '0) begin
                  done_d = 1'b1;
               end else if (end_addr > DEPTH_W) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_WAIT_DATA;
               end
            end else if (run_req) begin
               state_d = ST_START;
            end
         end
         ST_WAIT_DATA: begin
            if (lif.in_valid) begin
               data_d  = lif.in_data;
               cnt_d   = '0;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               state_d = ST_WRITE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_WRITE: begin
            cnt_d   = '0;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d = '0;
               rem_d = rem_q - LEN_ONE;
               if (rem_q == LEN_ONE) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = ST_WAIT_DATA;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_START: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (cpu_halt) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tgt_q   <= TGT_IRAM;
         addr_q  <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   logic              cpu_own;
   logic              ld_active;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;

   assign cpu_own   = (state_q == ST_RUN);
   assign ld_active = (state_q == ST_SETUP) || (state_q == ST_WRITE) || (state_q == ST_HOLD);
   assign ld_we     = (state_q == ST_WRITE);
   assign ld_addr   = ld_active ? addr_q : '0;
   assign ld_wdata  = ld_active ? data_q : '0;

   // Only the selected target sees the write; the other memory is parked at addr 0.
   always_comb begin
      iram_addr  = '0;
      iram_wdata = '0;
      iram_we    = 1'b0;
      if (cpu_own) begin
         iram_addr = cpu_iram_addr;
      end else if (tgt_q == TGT_IRAM) begin
         iram_addr  = ld_addr;
         iram_wdata = ld_wdata;
         iram_we    = ld_we;
      end
   end

   logic dram_sel;
   assign dram_sel = (tgt_q == TGT_DRAM);

   mem_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_dram_mux (
      .cpu_own   (cpu_own),
      .ld_addr   (dram_sel ? ld_addr : '0),
      .ld_wdata  (dram_sel ? ld_wdata : '0),
      .ld_we     (dram_sel && ld_we),
      .cpu_addr  (cpu_dram_addr),
      .cpu_wdata (cpu_dram_wdata),
      .cpu_we    (cpu_dram_we),
      .cpu_re    (cpu_dram_re),
      .mem_addr  (dram_addr),
      .mem_wdata (dram_wdata),
      .mem_we    (dram_we),
      .mem_re    (dram_re)
   );

   assign lif.cmd_ready = (state_q == ST_IDLE);
   assign lif.in_ready  = (state_q == ST_WAIT_DATA);
   assign cpu_start     = (state_q == ST_START);
   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign err           = err_q;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// tb/tb_mem_load_ctrl.sv - directed self-checking bench for mem_load_ctrl
module tb_mem_load_ctrl;

   logic        clk;
   logic        rst_n;
   logic        run_req;
   logic        cpu_start;
   logic        cpu_halt;
   logic [8:0]  cpu_iram_addr;
   logic [8:0]  cpu_dram_addr;
   logic [15:0] cpu_dram_wdata;
   logic        cpu_dram_we;
   logic        cpu_dram_re;
   logic [8:0]  iram_addr;
   logic [15:0] iram_wdata;
   logic        iram_we;
   logic [8:0]  dram_addr;
   logic [15:0] dram_wdata;
   logic        dram_we;
   logic        dram_re;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   mem_load_ctrl_if #(.ADDR_W(9), .DATA_W(16)) lif ();

   mem_load_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .lif            (lif),
      .run_req        (run_req),
      .cpu_start      (cpu_start),
      .cpu_halt       (cpu_halt),
      .cpu_iram_addr  (cpu_iram_addr),
      .cpu_dram_addr  (cpu_dram_addr),
      .cpu_dram_wdata (cpu_dram_wdata),
      .cpu_dram_we    (cpu_dram_we),
      .cpu_dram_re    (cpu_dram_re),
      .iram_addr      (iram_addr),
      .iram_wdata     (iram_wdata),
      .iram_we        (iram_we),
      .dram_addr      (dram_addr),
      .dram_wdata     (dram_wdata),
      .dram_we        (dram_we),
      .dram_re        (dram_re),
      .busy           (busy),
      .done           (done),
      .err            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models and write-pulse spacing, sampled mid-cycle.
   logic [15:0] iram_m [512];
   logic [15:0] dram_m [512];
   int iram_wc = 0;
   int dram_wc = 0;
   int cyc = 0;
   int iram_last = 0;
   int iram_gap = 0;
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (iram_we) begin
         iram_m[iram_addr] = iram_wdata;
         iram_wc = iram_wc + 1;
         iram_gap = cyc - iram_last;
         iram_last = cyc;
      end
      if (dram_we) begin
         dram_m[dram_addr] = dram_wdata;
         dram_wc = dram_wc + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic mem_we(input logic t);
      return t ? dram_we : iram_we;
   endfunction
   function automatic logic [8:0] mem_addr(input logic t);
      return t ? dram_addr : iram_addr;
   endfunction
   function automatic logic [15:0] mem_wdata(input logic t);
      return t ? dram_wdata : iram_wdata;
   endfunction
   function automatic logic oth_we(input logic t);
      return t ? iram_we : dram_we;
   endfunction
   function automatic logic [8:0] oth_addr(input logic t);
      return t ? iram_addr : dram_addr;
   endfunction

   task automatic issue_cmd(input logic t, input logic [8:0] base, input logic [9:0] len);
      lif.cmd_valid  = 1'b1;
      lif.cmd_target = t;
      lif.cmd_base   = base;
      lif.cmd_len    = len;
      step();
      lif.cmd_valid  = 1'b0;
   endtask

   task automatic word(input logic t, input logic [8:0] a, input logic [15:0] d, input bit last);
      int n = 0;
      lif.in_valid = 1'b1;
      lif.in_data  = d;
      while (!lif.in_ready && n < 40) begin
         step();
         n++;
      end
      chk("in_ready_wait", 32'(n < 40), 1);
      step();
      lif.in_valid = 1'b0;
      lif.in_data  = 16'h0;
      chk("setup_we", mem_we(t), 0);
      chk("setup_addr", mem_addr(t), a);
      chk("setup_wdata", mem_wdata(t), d);
      chk("setup_in_ready", lif.in_ready, 0);
      step();
      chk("write_we", mem_we(t), 1);
      chk("write_addr", mem_addr(t), a);
      chk("write_wdata", mem_wdata(t), d);
      chk("write_other_we", oth_we(t), 0);
      chk("write_other_addr", oth_addr(t), 0);
      step();
      chk("hold_we", mem_we(t), 0);
      chk("hold_addr", mem_addr(t), a);
      chk("hold_wdata", mem_wdata(t), d);
      step();
      if (last) begin
         chk("end_done", done, 1);
         chk("end_cmd_ready", lif.cmd_ready, 1);
         chk("end_busy", busy, 0);
      end else begin
         chk("next_in_ready", lif.in_ready, 1);
         chk("next_done", done, 0);
      end
   endtask

   initial begin
      int wc0;
      rst_n = 1'b0;
      run_req = 1'b0;
      cpu_halt = 1'b0;
      cpu_iram_addr = '0;
      cpu_dram_addr = '0;
      cpu_dram_wdata = '0;
      cpu_dram_we = 1'b0;
      cpu_dram_re = 1'b0;
      lif.cmd_valid = 1'b0;
      lif.cmd_target = 1'b0;
      lif.cmd_base = '0;
      lif.cmd_len = '0;
      lif.in_valid = 1'b0;
      lif.in_data = '0;
      #1;
      chk("rst_cmd_ready", lif.cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_iram_addr", iram_addr, 0);
      chk("rst_dram_we", dram_we, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("idle_cmd_ready", lif.cmd_ready, 1);
      chk("idle_in_ready", lif.in_ready, 0);
      chk("idle_cpu_start", cpu_start, 0);

      // 1: iram base 0, three back-to-back words
      wc0 = iram_wc;
      issue_cmd(1'b0, 9'd0, 10'd3);
      chk("t1_busy", busy, 1);
      chk("t1_in_ready", lif.in_ready, 1);
      word(1'b0, 9'd0, 16'h1111, 1'b0);
      word(1'b0, 9'd1, 16'h2222, 1'b0);
      chk("t1_gap1", iram_gap, 4);
      word(1'b0, 9'd2, 16'h3333, 1'b1);
      chk("t1_gap2", iram_gap, 4);
      step();
      chk("t1_done_single", done, 0);
      chk("t1_wcount", iram_wc - wc0, 3);
      chk("t1_rb0", iram_m[0], 16'h1111);
      chk("t1_rb1", iram_m[1], 16'h2222);
      chk("t1_rb2", iram_m[2], 16'h3333);

      // 2: out-of-range dram load, then the exact-fit load at the top
      wc0 = dram_wc;
      issue_cmd(1'b1, 9'd510, 10'd3);
      chk("t2_err", err, 1);
      chk("t2_cmd_ready", lif.cmd_ready, 1);
      chk("t2_busy", busy, 0);
      step();
      chk("t2_err_clear", err, 0);
      chk("t2_no_we", dram_wc - wc0, 0);
      issue_cmd(1'b1, 9'd509, 10'd3);
      chk("t2_ok_err", err, 0);
      word(1'b1, 9'd509, 16'h5090, 1'b0);
      word(1'b1, 9'd510, 16'h5100, 1'b0);
      word(1'b1, 9'd511, 16'h5110, 1'b1);
      chk("t2_wcount", dram_wc - wc0, 3);
      chk("t2_rb511", dram_m[511], 16'h5110);

      // 3: stalled stream between words
      wc0 = iram_wc;
      issue_cmd(1'b0, 9'd100, 10'd2);
      word(1'b0, 9'd100, 16'hA5A5, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_stall_in_ready", lif.in_ready, 1);
         chk("t3_stall_we", iram_we, 0);
      end
      word(1'b0, 9'd101, 16'h5A5A, 1'b1);
      chk("t3_wcount", iram_wc - wc0, 2);

      // 4: load then run; CPU owns dram and iram fetch address
      issue_cmd(1'b0, 9'd10, 10'd2);
      word(1'b0, 9'd10, 16'h00A0, 1'b0);
      word(1'b0, 9'd11, 16'h00A1, 1'b1);
      run_req = 1'b1;
      step();
      run_req = 1'b0;
      chk("t4_start", cpu_start, 1);
      chk("t4_start_busy", busy, 1);
      step();
      chk("t4_start_once", cpu_start, 0);
      chk("t4_run_cmd_ready", lif.cmd_ready, 0);
      cpu_iram_addr = 9'h055;
      cpu_dram_addr = 9'd7;
      cpu_dram_wdata = 16'hABCD;
      cpu_dram_we = 1'b1;
      cpu_dram_re = 1'b1;
      lif.cmd_valid = 1'b1;
      lif.cmd_len = 10'd1;
      #1;
      chk("t4_dram_we", dram_we, 1);
      chk("t4_dram_re", dram_re, 1);
      chk("t4_dram_addr", dram_addr, 9'd7);
      chk("t4_dram_wdata", dram_wdata, 16'hABCD);
      chk("t4_iram_addr", iram_addr, 9'h055);
      chk("t4_iram_we", iram_we, 0);
      step();
      lif.cmd_valid = 1'b0;
      cpu_dram_we = 1'b0;
      cpu_dram_re = 1'b0;
      chk("t4_cmd_ignored", lif.in_ready, 0);
      chk("t4_still_busy", busy, 1);
      chk("t4_rb7", dram_m[7], 16'hABCD);
      cpu_halt = 1'b1;
      step();
      cpu_halt = 1'b0;
      chk("t4_halt_idle", lif.cmd_ready, 1);
      chk("t4_halt_busy", busy, 0);
      cpu_dram_we = 1'b1;
      cpu_dram_re = 1'b1;
      #1;
      chk("t4_mask_we", dram_we, 0);
      chk("t4_mask_re", dram_re, 0);
      chk("t4_idle_iram_addr", iram_addr, 0);
      cpu_dram_we = 1'b0;
      cpu_dram_re = 1'b0;

      // 5: async reset during WRITE, then a fresh single-word load
      step();
      issue_cmd(1'b0, 9'd200, 10'd4);
      lif.in_valid = 1'b1;
      lif.in_data = 16'hC0DE;
      step();
      lif.in_valid = 1'b0;
      step();
      chk("t5_in_write", iram_we, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_we", iram_we, 0);
      chk("t5_rst_addr", iram_addr, 0);
      chk("t5_rst_wdata", iram_wdata, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_cmd_ready", lif.cmd_ready, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("t5_rel_cmd_ready", lif.cmd_ready, 1);
      chk("t5_rel_in_ready", lif.in_ready, 0);
      issue_cmd(1'b0, 9'd300, 10'd1);
      word(1'b0, 9'd300, 16'h0300, 1'b1);
      chk("t5_rb300", iram_m[300], 16'h0300);

      // 6: command beats run_req; run follows once loading finishes; len=0
      step();
      run_req = 1'b1;
      issue_cmd(1'b1, 9'd20, 10'd1);
      chk("t6_cmd_first", lif.in_ready, 1);
      chk("t6_no_start", cpu_start, 0);
      word(1'b1, 9'd20, 16'h2020, 1'b1);
      step();
      chk("t6_start_after", cpu_start, 1);
      run_req = 1'b0;
      step();
      cpu_halt = 1'b1;
      step();
      cpu_halt = 1'b0;
      chk("t6_back_idle", lif.cmd_ready, 1);
      wc0 = iram_wc + dram_wc;
      issue_cmd(1'b0, 9'd5, 10'd0);
      chk("t6_len0_done", done, 1);
      chk("t6_len0_busy", busy, 0);
      step();
      chk("t6_len0_done_clear", done, 0);
      chk("t6_len0_no_we", iram_wc + dram_wc - wc0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
